// File: rtl/mem_copy_master.sv
// Byte-at-a-time block copy master for a single-port memory with registered read data.
// Optional fill mode (constant-value writes, no reads) is enabled by MEM_COPY_MASTER_FILL_EN.
module mem_copy_master #(
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] srcAddr,
    input  logic [ADDR_WIDTH-1:0] dstAddr,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef MEM_COPY_MASTER_FILL_EN
    input  logic                  fillMode,
    input  logic [DATA_SIZE-1:0]  fillValue,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  readEnable,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] rw_Addr,
    output logic [DATA_SIZE-1:0]  writeData,
    input  logic [DATA_SIZE-1:0]  readData
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] srcPtr_q, srcPtr_d;
    logic [ADDR_WIDTH-1:0] dstPtr_q, dstPtr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  readEnable_q, readEnable_d;
    logic                  writeEnable_q, writeEnable_d;
    logic [ADDR_WIDTH-1:0] rw_Addr_q, rw_Addr_d;
    logic [DATA_SIZE-1:0]  writeData_q, writeData_d;
    state_t                byteStart;
`ifdef MEM_COPY_MASTER_FILL_EN
    logic                  fillMode_q, fillMode_d;
    logic [DATA_SIZE-1:0]  fillValue_q, fillValue_d;
`endif

    always_comb begin
        state_d     = state_q;
        srcPtr_d    = srcPtr_q;
        dstPtr_d    = dstPtr_q;
        remaining_d = remaining_q;
        byteStart   = S_READ;
`ifdef MEM_COPY_MASTER_FILL_EN
        fillMode_d  = fillMode_q;
        fillValue_d = fillValue_q;
        if (state_q == S_IDLE && start) begin
            fillMode_d  = fillMode;
            fillValue_d = fillValue;
        end
        // Fill bytes need no read, so each byte starts directly in WRITE.
        if (fillMode_d) byteStart = S_WRITE;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    srcPtr_d    = srcAddr;
                    dstPtr_d    = dstAddr;
                    remaining_d = length;
                    state_d     = (length == '0) ? S_DONE : byteStart;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_WRITE;
            S_WRITE: begin
                srcPtr_d    = srcPtr_q + ADDR_ONE;
                dstPtr_d    = dstPtr_q + ADDR_ONE;
                remaining_d = remaining_q - LEN_ONE;
                state_d     = (remaining_q > LEN_ONE) ? byteStart : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        busy_d        = (state_d == S_READ) || (state_d == S_WAIT) || (state_d == S_WRITE);
        done_d        = (state_d == S_DONE);
        readEnable_d  = (state_d == S_READ);
        writeEnable_d = (state_d == S_WRITE);
        rw_Addr_d     = rw_Addr_q;
        writeData_d   = writeData_q;
        if (state_d == S_READ) begin
            rw_Addr_d = srcPtr_d;
        end else if (state_d == S_WRITE) begin
            rw_Addr_d   = dstPtr_d;
            writeData_d = readData;
`ifdef MEM_COPY_MASTER_FILL_EN
            if (fillMode_d) writeData_d = fillValue_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            srcPtr_q      <= '0;
            dstPtr_q      <= '0;
            remaining_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            readEnable_q  <= 1'b0;
            writeEnable_q <= 1'b0;
            rw_Addr_q     <= '0;
            writeData_q   <= '0;
`ifdef MEM_COPY_MASTER_FILL_EN
            fillMode_q    <= 1'b0;
            fillValue_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            srcPtr_q      <= srcPtr_d;
            dstPtr_q      <= dstPtr_d;
            remaining_q   <= remaining_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            readEnable_q  <= readEnable_d;
            writeEnable_q <= writeEnable_d;
            rw_Addr_q     <= rw_Addr_d;
            writeData_q   <= writeData_d;
`ifdef MEM_COPY_MASTER_FILL_EN
            fillMode_q    <= fillMode_d;
            fillValue_q   <= fillValue_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign readEnable  = readEnable_q;
    assign writeEnable = writeEnable_q;
    assign rw_Addr     = rw_Addr_q;
    assign writeData   = writeData_q;

endmodule
